rx_hold_drain: RTL and testbench



---
 rtl/rx_pkg.sv | 31 +++
 rtl/rx_sat_counter.sv | 33 +++
 rtl/rx_hold_drain.sv | 193 +++++++++++++++++++
 tb/tb_rx_hold_drain.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the RX hold-FIFO drain path.
// Status byte layout: bit5 SOP, bit6 EOP, bit7 ERR, bits[2:0] valid bytes in
// the EOP word (0 means 8).
package rx_pkg;

    localparam int unsigned RXSTATUS_SOP       = 5;
    localparam int unsigned RXSTATUS_EOP       = 6;
    localparam int unsigned RXSTATUS_ERR       = 7;
    localparam int unsigned RXSTATUS_BYTES_MSB = 2;

    localparam int unsigned RX_STATUS_W = 8;
    localparam int unsigned RX_DATA_W   = 64;
    localparam int unsigned RX_LEN_W    = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        DISCARD = 2'd2
    } rx_state_e;

    // Status for a forced frame terminator: EOP|ERR, byte count cleared.
    function automatic logic [RX_STATUS_W-1:0] rx_eop_err_status();
        logic [RX_STATUS_W-1:0] s;
        s                         = '0;
        s[RXSTATUS_BYTES_MSB:0]   = '0;
        s[RXSTATUS_EOP]           = 1'b1;
        s[RXSTATUS_ERR]           = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating increment counter with synchronous active-high reset.
// Ports: clk, rst (sync, active-high), inc (count enable), count (value).
module rx_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Hold at all-ones once reached.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rx_hold_drain.sv
// Drains the 72-bit show-ahead RX hold FIFO into the RX data FIFO, holding
// back the last 7 words until a frame end has been committed upstream, and
// enforcing SOP/EOP framing with frame/error/stray statistics.
// Optional build macro: RX_MAX_LEN_CHECK_EN adds a per-frame length limit
// (MAX_WORDS) that truncates oversize frames with EOP|ERR and discards the rest.
// Ports:
//   clk_xgmii_rx, reset_xgmii_rx  clock, synchronous active-high reset
//   rxhfifo_*                     hold FIFO read side (head word, flags, pop)
//   hold_eop_commit               pulse per EOP word written into the hold FIFO
//   rxdfifo_*                     data FIFO write side (registered, latency 1)
//   stat_*                        saturating frame/error/stray counters
module rx_hold_drain
    import rx_pkg::*;
#(
    parameter int unsigned EOP_CNT_W = 4,
    parameter int unsigned STAT_W    = 32,
    parameter int unsigned MAX_WORDS = 1520
) (
    input  logic                   clk_xgmii_rx,
    input  logic                   reset_xgmii_rx,
    input  logic [RX_DATA_W-1:0]   rxhfifo_rdata,
    input  logic [RX_STATUS_W-1:0] rxhfifo_rstatus,
    input  logic                   rxhfifo_rempty,
    input  logic                   rxhfifo_ralmost_empty,
    output logic                   rxhfifo_ren,
    input  logic                   hold_eop_commit,
    input  logic                   rxdfifo_walmost_full,
    output logic [RX_DATA_W-1:0]   rxdfifo_wdata,
    output logic [RX_STATUS_W-1:0] rxdfifo_wstatus,
    output logic                   rxdfifo_wen,
    output logic [STAT_W-1:0]      stat_frames,
    output logic [STAT_W-1:0]      stat_err_frames,
    output logic [STAT_W-1:0]      stat_stray
);

    rx_state_e                state_q, state_d;
    logic [EOP_CNT_W-1:0]     eop_pending_q, eop_pending_d;
    logic                     wen_q, wen_d;
    logic [RX_DATA_W-1:0]     wdata_q, wdata_d;
    logic [RX_STATUS_W-1:0]   wstatus_q, wstatus_d;
    logic                     inc_frames, inc_err_frames, inc_stray;
    logic                     head_sop, head_eop, head_err;
`ifdef RX_MAX_LEN_CHECK_EN
    logic [RX_LEN_W-1:0]      word_cnt_q, word_cnt_d;
`endif

    assign head_sop = rxhfifo_rstatus[RXSTATUS_SOP];
    assign head_eop = rxhfifo_rstatus[RXSTATUS_EOP];
    assign head_err = rxhfifo_rstatus[RXSTATUS_ERR];

    // Pop: the last 7 words stay put unless a committed EOP is in the FIFO.
    always_comb begin
        rxhfifo_ren = !rxhfifo_rempty && !rxdfifo_walmost_full &&
                      (!rxhfifo_ralmost_empty || (eop_pending_q != '0));
    end

    // Committed-EOP count; saturates at both ends, simultaneous +/- cancel.
    always_comb begin
        eop_pending_d = eop_pending_q;
        if (hold_eop_commit && !(rxhfifo_ren && head_eop)) begin
            if (eop_pending_q != '1) begin
                eop_pending_d = eop_pending_q + EOP_CNT_W'(1);
            end
        end else if (!hold_eop_commit && rxhfifo_ren && head_eop) begin
            if (eop_pending_q != '0) begin
                eop_pending_d = eop_pending_q - EOP_CNT_W'(1);
            end
        end
    end

    // Framing FSM, evaluated on each popped word.
    always_comb begin
        state_d        = state_q;
        wen_d          = 1'b0;
        wdata_d        = wdata_q;
        wstatus_d      = wstatus_q;
        inc_frames     = 1'b0;
        inc_err_frames = 1'b0;
        inc_stray      = 1'b0;
`ifdef RX_MAX_LEN_CHECK_EN
        word_cnt_d     = word_cnt_q;
`endif
        if (rxhfifo_ren) begin
            wdata_d   = rxhfifo_rdata;
            wstatus_d = rxhfifo_rstatus;
            case (state_q)
                IDLE: begin
                    if (head_sop) begin
                        wen_d = 1'b1;
                        if (head_eop) begin
                            inc_frames     = !head_err;
                            inc_err_frames = head_err;
                        end else begin
                            state_d = FRAME;
`ifdef RX_MAX_LEN_CHECK_EN
                            word_cnt_d = RX_LEN_W'(1);
`endif
                        end
                    end else begin
                        inc_stray = 1'b1;
                    end
                end
                FRAME: begin
                    wen_d = 1'b1;
                    if (head_sop) begin
                        // Missing EOP: close the old frame using the SOP word
                        // as filler; the new frame's head is lost.
                        wstatus_d      = rx_eop_err_status();
                        inc_err_frames = 1'b1;
                        inc_stray      = 1'b1;
`ifdef RX_MAX_LEN_CHECK_EN
                        word_cnt_d     = RX_LEN_W'(1);
`endif
                    end else if (head_eop) begin
                        state_d        = IDLE;
                        inc_frames     = !head_err;
                        inc_err_frames = head_err;
`ifdef RX_MAX_LEN_CHECK_EN
                    end else if (word_cnt_q == RX_LEN_W'(MAX_WORDS)) begin
                        // Word MAX_WORDS+1 without EOP: truncate the frame.
                        wstatus_d      = rx_eop_err_status();
                        inc_err_frames = 1'b1;
                        state_d        = DISCARD;
                    end else begin
                        word_cnt_d = word_cnt_q + RX_LEN_W'(1);
`else
                    end else begin
                        wen_d = 1'b1;
`endif
                    end
                end
`ifdef RX_MAX_LEN_CHECK_EN
                DISCARD: begin
                    if (head_eop) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_xgmii_rx) begin
        if (reset_xgmii_rx) begin
            state_q       <= IDLE;
            eop_pending_q <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            wstatus_q     <= '0;
`ifdef RX_MAX_LEN_CHECK_EN
            word_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            eop_pending_q <= eop_pending_d;
            wen_q         <= wen_d;
            wdata_q       <= wdata_d;
            wstatus_q     <= wstatus_d;
`ifdef RX_MAX_LEN_CHECK_EN
            word_cnt_q    <= word_cnt_d;
`endif
        end
    end

    assign rxdfifo_wen     = wen_q;
    assign rxdfifo_wdata   = wdata_q;
    assign rxdfifo_wstatus = wstatus_q;

    rx_sat_counter #(.W(STAT_W)) u_stat_frames (
        .clk   (clk_xgmii_rx),
        .rst   (reset_xgmii_rx),
        .inc   (inc_frames),
        .count (stat_frames)
    );

    rx_sat_counter #(.W(STAT_W)) u_stat_err_frames (
        .clk   (clk_xgmii_rx),
        .rst   (reset_xgmii_rx),
        .inc   (inc_err_frames),
        .count (stat_err_frames)
    );

    rx_sat_counter #(.W(STAT_W)) u_stat_stray (
        .clk   (clk_xgmii_rx),
        .rst   (reset_xgmii_rx),
        .inc   (inc_stray),
        .count (stat_stray)
    );

endmodule

// File: tb/tb_rx_hold_drain.sv
// Testbench for rx_hold_drain: models the hold FIFO as a queue, predicts the
// data FIFO writes and statistics from the framing rules, and checks writes
// through a scoreboard drained by an independent monitor.
// Honours RX_MAX_LEN_CHECK_EN (uses MAX_WORDS=4 when defined).
module tb_rx_hold_drain;
    import rx_pkg::*;

`ifdef RX_MAX_LEN_CHECK_EN
    localparam int unsigned MAXW   = 4;
    localparam bit          LEN_EN = 1'b1;
`else
    localparam int unsigned MAXW   = 1520;
    localparam bit          LEN_EN = 1'b0;
`endif
    localparam int unsigned SW = 32;

    logic          clk_xgmii_rx;
    logic          reset_xgmii_rx;
    logic [63:0]   rxhfifo_rdata;
    logic [7:0]    rxhfifo_rstatus;
    logic          rxhfifo_rempty;
    logic          rxhfifo_ralmost_empty;
    logic          rxhfifo_ren;
    logic          hold_eop_commit;
    logic          rxdfifo_walmost_full;
    logic [63:0]   rxdfifo_wdata;
    logic [7:0]    rxdfifo_wstatus;
    logic          rxdfifo_wen;
    logic [SW-1:0] stat_frames;
    logic [SW-1:0] stat_err_frames;
    logic [SW-1:0] stat_stray;

    rx_hold_drain #(.EOP_CNT_W(4), .STAT_W(SW), .MAX_WORDS(MAXW)) dut (
        .clk_xgmii_rx          (clk_xgmii_rx),
        .reset_xgmii_rx        (reset_xgmii_rx),
        .rxhfifo_rdata         (rxhfifo_rdata),
        .rxhfifo_rstatus       (rxhfifo_rstatus),
        .rxhfifo_rempty        (rxhfifo_rempty),
        .rxhfifo_ralmost_empty (rxhfifo_ralmost_empty),
        .rxhfifo_ren           (rxhfifo_ren),
        .hold_eop_commit       (hold_eop_commit),
        .rxdfifo_walmost_full  (rxdfifo_walmost_full),
        .rxdfifo_wdata         (rxdfifo_wdata),
        .rxdfifo_wstatus       (rxdfifo_wstatus),
        .rxdfifo_wen           (rxdfifo_wen),
        .stat_frames           (stat_frames),
        .stat_err_frames       (stat_err_frames),
        .stat_stray            (stat_stray)
    );

    initial clk_xgmii_rx = 1'b0;
    always #5 clk_xgmii_rx = ~clk_xgmii_rx;

    logic [71:0] hq[$];      // hold FIFO contents, head at index 0
    logic [71:0] src[$];     // words waiting to be written into the hold FIFO
    logic [71:0] exp_q[$];   // expected data FIFO writes
    logic [71:0] wr_log[$];  // every observed data FIFO write
    logic [71:0] frm[$];

    int n_pass = 0;
    int n_total = 0;
    int n_pops = 0;
    int n_wr = 0;
    int pend_m = 0;
    bit ren_s = 0, commit_s = 0, commit_req = 0;
    bit afull_v = 0, feed_auto = 0, rand_bp = 0;

    // Reference model: 0 outside a frame, 1 inside, 2 dropping an oversize tail.
    int mstate = 0;
    int mcnt = 0;
    int m_frames = 0, m_err = 0, m_stray = 0;

    localparam logic [7:0] ST_EOP_ERR = 8'hC0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [71:0] mk(input logic [7:0] st);
        return {st, 32'($urandom), 32'($urandom)};
    endfunction

    task automatic ref_word(input logic [71:0] w);
        logic sop, eop, err;
        sop = w[64+RXSTATUS_SOP];
        eop = w[64+RXSTATUS_EOP];
        err = w[64+RXSTATUS_ERR];
        if (mstate == 0) begin
            if (sop) begin
                exp_q.push_back(w);
                if (eop) begin
                    if (err) m_err++; else m_frames++;
                end else begin
                    mstate = 1; mcnt = 1;
                end
            end else begin
                m_stray++;
            end
        end else if (mstate == 1) begin
            if (sop) begin
                exp_q.push_back({ST_EOP_ERR, w[63:0]});
                m_err++; m_stray++; mcnt = 1;
            end else if (eop) begin
                exp_q.push_back(w);
                mstate = 0;
                if (err) m_err++; else m_frames++;
            end else if (LEN_EN && mcnt == int'(MAXW)) begin
                exp_q.push_back({ST_EOP_ERR, w[63:0]});
                m_err++; mstate = 2;
            end else begin
                exp_q.push_back(w);
                mcnt++;
            end
        end else begin
            if (eop) mstate = 0;
        end
    endtask

    // One clock: settle the pop of the edge just past, then drive the next cycle.
    task automatic tick();
        logic [71:0] w;
        bit inc, dec, commit_now, exp_ren;
        @(negedge clk_xgmii_rx);
        dec = 1'b0;
        if (ren_s) begin
            w = hq.pop_front();
            n_pops++;
            ref_word(w);
            dec = w[64+RXSTATUS_EOP];
        end
        inc = commit_s;
        if (inc && !dec && pend_m < 15) pend_m++;
        else if (dec && !inc && pend_m > 0) pend_m--;
        commit_now = commit_req;
        commit_req = 1'b0;
        if (feed_auto && src.size() != 0 && hq.size() < 12 && $urandom_range(0, 3) != 0) begin
            w = src.pop_front();
            hq.push_back(w);
            if (w[64+RXSTATUS_EOP]) commit_now = 1'b1;
        end
        if (rand_bp) afull_v = ($urandom_range(0, 3) == 0);
        hold_eop_commit       = commit_now;
        commit_s              = commit_now;
        rxhfifo_rempty        = (hq.size() == 0);
        rxhfifo_ralmost_empty = (hq.size() <= 7);
        if (hq.size() != 0) {rxhfifo_rstatus, rxhfifo_rdata} = hq[0];
        else {rxhfifo_rstatus, rxhfifo_rdata} = '0;
        rxdfifo_walmost_full = afull_v;
        #2;
        exp_ren = (hq.size() != 0) && !afull_v && (hq.size() > 7 || pend_m != 0);
        check("ren", 72'(rxhfifo_ren), 72'(exp_ren));
        ren_s = rxhfifo_ren;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (hq.size() == 0 && src.size() == 0 && !ren_s && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL %s_drain: timeout with %0d held, %0d writes outstanding", name, hq.size(), exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic build_frame(input int len, input bit err, input bit with_eop);
        logic [7:0] st;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            st = 8'($urandom_range(0, 31));
            if (i == 0) st[RXSTATUS_SOP] = 1'b1;
            if (with_eop && i == len - 1) begin
                st[RXSTATUS_EOP] = 1'b1;
                st[RXSTATUS_ERR] = err;
            end
            frm.push_back(mk(st));
        end
    endtask

    task automatic check_stats(input string name);
        check({name, "_frames"}, 72'(stat_frames), 72'(m_frames));
        check({name, "_err"},    72'(stat_err_frames), 72'(m_err));
        check({name, "_stray"},  72'(stat_stray), 72'(m_stray));
    endtask

    task automatic check_wr_status(input string name, input int idx);
        logic [71:0] w;
        if (wr_log.size() > idx) begin
            w = wr_log[idx];
            check(name, 72'(w[71:64]), 72'(ST_EOP_ERR));
        end else begin
            n_total++;
            $display("FAIL %s: got no write #%0d expected status %h", name, idx, ST_EOP_ERR);
        end
    endtask

    // Monitor: every data FIFO write is matched against the scoreboard.
    initial begin
        logic [71:0] e;
        forever begin
            @(negedge clk_xgmii_rx);
            #1;
            if (rxdfifo_wen === 1'b1) begin
                n_wr++;
                wr_log.push_back({rxdfifo_wstatus, rxdfifo_wdata});
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_extra: got %h expected no write", {rxdfifo_wstatus, rxdfifo_wdata});
                end else begin
                    e = exp_q.pop_front();
                    check("wr_word", {rxdfifo_wstatus, rxdfifo_wdata}, e);
                end
            end
        end
    end

    initial begin
        int wr0, p0, e0, s0, f0, r;
        reset_xgmii_rx        = 1'b1;
        rxhfifo_rdata         = '0;
        rxhfifo_rstatus       = '0;
        rxhfifo_rempty        = 1'b1;
        rxhfifo_ralmost_empty = 1'b1;
        hold_eop_commit       = 1'b0;
        rxdfifo_walmost_full  = 1'b0;
        repeat (3) tick();
        reset_xgmii_rx = 1'b0;
        tick();
        check("rst_wen",     72'(rxdfifo_wen), 72'(0));
        check("rst_wdata",   72'(rxdfifo_wdata), 72'(0));
        check("rst_wstatus", 72'(rxdfifo_wstatus), 72'(0));
        check_stats("rst");

        // 10-word good frame, one commit: everything drains.
        wr0 = n_wr;
        build_frame(10, 1'b0, 1'b1);
        foreach (frm[i]) hq.push_back(frm[i]);
        commit_req = 1'b1;
        drain("t1");
        check("t1_writes", 72'(n_wr - wr0), 72'(10));
        check("t1_frames", 72'(stat_frames), 72'(1));

        // 9 words, no commit: only 2 leave until the commit arrives.
        p0 = n_pops;
        build_frame(9, 1'b0, 1'b1);
        foreach (frm[i]) hq.push_back(frm[i]);
        repeat (20) tick();
        check("t2_pops_held", 72'(n_pops - p0), 72'(2));
        commit_req = 1'b1;
        drain("t2");
        check("t2_pops_total", 72'(n_pops - p0), 72'(9));

        // Backpressure for 5 cycles mid-frame.
        wr0 = n_wr;
        build_frame(10, 1'b0, 1'b1);
        foreach (frm[i]) hq.push_back(frm[i]);
        commit_req = 1'b1;
        repeat (3) tick();
        afull_v = 1'b1;
        repeat (5) begin
            tick();
            check("t3_bp_ren", 72'(rxhfifo_ren), 72'(0));
        end
        afull_v = 1'b0;
        drain("t3");
        check("t3_writes", 72'(n_wr - wr0), 72'(10));

        // 3 stray words then a single-word errored frame.
        wr0 = n_wr; e0 = m_err; s0 = m_stray;
        repeat (3) hq.push_back(mk(8'($urandom_range(0, 31)) | 8'h80));
        hq.push_back(mk(8'hE0 | 8'($urandom_range(0, 7))));
        commit_req = 1'b1;
        drain("t4");
        check("t4_writes", 72'(n_wr - wr0), 72'(1));
        check("t4_stray",  72'(stat_stray), 72'(s0 + 3));
        check("t4_err",    72'(stat_err_frames), 72'(e0 + 1));

        // SOP arriving inside a frame forces an EOP|ERR terminator.
        wr0 = n_wr; e0 = m_err; s0 = m_stray; f0 = m_frames;
        build_frame(2, 1'b0, 1'b0);
        foreach (frm[i]) hq.push_back(frm[i]);
        hq.push_back(mk(8'h20));
        hq.push_back(mk(8'h03));
        hq.push_back(mk(8'h45));
        commit_req = 1'b1;
        drain("t5");
        check("t5_writes", 72'(n_wr - wr0), 72'(5));
        check_wr_status("t5_abort_status", wr0 + 2);
        check("t5_err",    72'(stat_err_frames), 72'(e0 + 1));
        check("t5_stray",  72'(stat_stray), 72'(s0 + 1));
        check("t5_frames", 72'(stat_frames), 72'(f0 + 1));

        // 8-word frame: truncated when the length limit is built in.
        wr0 = n_wr; e0 = m_err; f0 = m_frames;
        build_frame(8, 1'b0, 1'b1);
        foreach (frm[i]) hq.push_back(frm[i]);
        commit_req = 1'b1;
        drain("t6");
`ifdef RX_MAX_LEN_CHECK_EN
        check("t6_writes", 72'(n_wr - wr0), 72'(5));
        check_wr_status("t6_trunc_status", wr0 + 4);
        check("t6_err",    72'(stat_err_frames), 72'(e0 + 1));
`else
        check("t6_writes", 72'(n_wr - wr0), 72'(8));
        check("t6_frames", 72'(stat_frames), 72'(f0 + 1));
`endif
        check_stats("directed");

        // Random traffic with random backpressure.
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                src.push_back(mk(8'($urandom) & 8'hDF));
            end else if (r < 8) begin
                build_frame(int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)), 1'b1);
                foreach (frm[i]) src.push_back(frm[i]);
            end else begin
                build_frame(int'($urandom_range(1, 4)), 1'b0, 1'b0);
                foreach (frm[i]) src.push_back(frm[i]);
            end
        end
        src.push_back(mk(8'h60));
        feed_auto = 1'b1;
        rand_bp   = 1'b1;
        for (int i = 0; i < 5000 && src.size() != 0; i++) tick();
        rand_bp = 1'b0;
        afull_v = 1'b0;
        drain("rand");
        check_stats("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
